// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result skid buffer with in-order writeback and flag commit (optional STICKY_OVF_EN)
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int DEST_W = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] Result,
    input  logic              Zero,
    input  logic              Overflow,
    input  logic              CarryOut,
    input  logic [DEST_W-1:0] DestReg,
    input  logic              RegWrite,
    input  logic              FlagWrite,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [DEST_W-1:0] OutDest,
    output logic              OutRegWrite,
`ifdef STICKY_OVF_EN
    input  logic              OvClear,
    output logic              OvSticky,
`endif
    output logic [3:0]        Flags
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              overflow;
        logic              carry;
        logic [DEST_W-1:0] dest;
        logic              reg_write;
        logic              flag_write;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t h_q, h_d, s_q, s_d, in_entry;
    logic   in_ready_q, in_ready_d;
    logic [3:0] flags_q, flags_d;
    logic   accept, retire;

    assign in_entry = '{result: Result, zero: Zero, overflow: Overflow, carry: CarryOut,
                        dest: DestReg, reg_write: RegWrite, flag_write: FlagWrite};

    assign accept = InValid & in_ready_q;
    assign retire = (state_q != EMPTY) & OutReady;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        flags_d = flags_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    h_d     = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    h_d = in_entry;
                end else if (accept) begin
                    s_d     = in_entry;
                    state_d = FULL;
                end else if (retire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (retire) begin
                    h_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flags follow the entry leaving the stage, so they match the last retired result.
        if (retire && h_q.flag_write) begin
            flags_d = {h_q.result[DATA_W-1], h_q.zero, h_q.overflow, h_q.carry};
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= EMPTY;
            h_q        <= '0;
            s_q        <= '0;
            flags_q    <= 4'b0000;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            s_q        <= s_d;
            flags_q    <= flags_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef STICKY_OVF_EN
    logic ov_sticky_q, ov_sticky_d;

    // Set has priority over clear when both occur together.
    assign ov_sticky_d = (retire & h_q.overflow) | (ov_sticky_q & ~OvClear);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ov_sticky_q <= 1'b0;
        end else begin
            ov_sticky_q <= ov_sticky_d;
        end
    end

    assign OvSticky = ov_sticky_q;
`endif

    assign InReady     = in_ready_q;
    assign OutValid    = (state_q != EMPTY);
    assign OutData     = h_q.result;
    assign OutDest     = h_q.dest;
    assign OutRegWrite = h_q.reg_write & OutValid;
    assign Flags       = flags_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - randomized and directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

    logic        Clock;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [15:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        CarryOut;
    logic [2:0]  DestReg;
    logic        RegWrite;
    logic        FlagWrite;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] OutData;
    logic [2:0]  OutDest;
    logic        OutRegWrite;
    logic [3:0]  Flags;
`ifdef STICKY_OVF_EN
    logic        OvClear;
    logic        OvSticky;
`endif

    alu_result_stage #(.DATA_W(16), .DEST_W(3)) dut (
        .Clock(Clock), .Reset(Reset),
        .InValid(InValid), .InReady(InReady),
        .Result(Result), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut),
        .DestReg(DestReg), .RegWrite(RegWrite), .FlagWrite(FlagWrite),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutData(OutData), .OutDest(OutDest), .OutRegWrite(OutRegWrite),
`ifdef STICKY_OVF_EN
        .OvClear(OvClear), .OvSticky(OvSticky),
`endif
        .Flags(Flags)
    );

    typedef struct {
        logic [15:0] res;
        logic        z, v, c;
        logic [2:0]  d;
        logic        rw, fw;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] retired[$];
    logic [3:0]  m_flags;
    logic        m_sticky;
    logic        last_acc;
    int          total;
    int          bad;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ovalid"}, OutValid, m_q.size() != 0);
        check({tag, "_iready"}, InReady, m_q.size() < 2);
        check({tag, "_flags"}, Flags, m_flags);
        if (m_q.size() != 0) begin
            check({tag, "_odata"}, OutData, m_q[0].res);
            check({tag, "_odest"}, OutDest, m_q[0].d);
            check({tag, "_orw"}, OutRegWrite, m_q[0].rw);
        end else begin
            check({tag, "_orw0"}, OutRegWrite, 1'b0);
        end
`ifdef STICKY_OVF_EN
        check({tag, "_sticky"}, OvSticky, m_sticky);
`endif
    endtask

    // One clock: decide accept/retire from the queue model, advance it, then compare at negedge.
    task automatic cycle(input string tag);
        bit   acc, ret, clr;
        ent_t e;
        acc = InValid && (m_q.size() < 2);
        ret = OutReady && (m_q.size() > 0);
        clr = 1'b0;
`ifdef STICKY_OVF_EN
        clr = OvClear;
`endif
        @(posedge Clock);
        if (ret) begin
            e = m_q.pop_front();
            retired.push_back(e.res);
            if (e.fw) m_flags = {e.res[15], e.z, e.v, e.c};
            if (e.v) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
        end else if (clr) begin
            m_sticky = 1'b0;
        end
        if (acc) m_q.push_back('{res: Result, z: Zero, v: Overflow, c: CarryOut,
                                 d: DestReg, rw: RegWrite, fw: FlagWrite});
        last_acc = acc;
        @(negedge Clock);
        check_outputs(tag);
    endtask

    task automatic drive(input logic [15:0] r, input logic z, input logic v, input logic c,
                         input logic [2:0] d, input logic rw, input logic fw);
        InValid = 1'b1; Result = r; Zero = z; Overflow = v; CarryOut = c;
        DestReg = d; RegWrite = rw; FlagWrite = fw;
    endtask

    task automatic drain();
        InValid  = 1'b0;
        OutReady = 1'b1;
        repeat (3) cycle("drain");
    endtask

    initial begin
        total = 0; bad = 0;
        m_flags = 4'b0000; m_sticky = 1'b0; last_acc = 1'b0;
        Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        Result = '0; Zero = 0; Overflow = 0; CarryOut = 0; DestReg = '0; RegWrite = 0; FlagWrite = 0;
`ifdef STICKY_OVF_EN
        OvClear = 1'b0;
`endif
        repeat (2) @(negedge Clock);
        check_outputs("reset");
        check("reset_odata", OutData, 16'h0000);
        Reset = 1'b1;
        @(negedge Clock);

        // Single entry: latency 1, flags 1011 after retire.
        OutReady = 1'b1;
        drive(16'h8000, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
        cycle("t2_acc");
        check("t2_ovalid", OutValid, 1'b1);
        check("t2_odata", OutData, 16'h8000);
        check("t2_odest", OutDest, 3'd3);
        InValid = 1'b0;
        cycle("t2_ret");
        check("t2_flags", Flags, 4'b1011);

        // FlagWrite=0 entry leaves flags alone; RegWrite=0 entry gates OutRegWrite.
        drive(16'h0000, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0);
        cycle("t5_acc");
        check("t5_ovalid", OutValid, 1'b1);
        check("t5_orw", OutRegWrite, 1'b0);
        InValid = 1'b0;
        cycle("t5_ret");
        check("t5_flags", Flags, 4'b1011);

        // Fill with OutReady low: third push is refused, then all three drain in order.
        OutReady = 1'b0;
        retired.delete();
        for (int i = 1; i <= 3; i++) begin
            drive(i[15:0], 1'b0, 1'b0, 1'b0, i[2:0], 1'b1, 1'b0);
            cycle("t3_fill");
        end
        check("t3_third_acc", last_acc, 1'b0);
        check("t3_iready", InReady, 1'b0);
        OutReady = 1'b1;
        cycle("t3_d0");
        cycle("t3_d1");
        InValid = 1'b0;
        cycle("t3_d2");
        check("t3_nret", retired.size(), 3);
        for (int i = 0; i < 3 && i < retired.size(); i++)
            check("t3_order", retired[i], i + 1);

        // Streaming: one retire per cycle, InReady stays high.
        for (int i = 0; i < 10; i++) begin
            drive(16'h1000 + i[15:0], 1'b0, 1'b0, 1'b0, i[2:0], 1'b1, 1'b0);
            cycle("t4_stream");
            check("t4_iready", InReady, 1'b1);
            check("t4_count", m_q.size(), 1);
        end
        drain();

`ifdef STICKY_OVF_EN
        begin
            logic [1:0] st_seq [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
            logic       st_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                if (i < 3) begin
                    drive(16'h0042, 1'b0, st_seq[i][1], 1'b0, 3'd1, 1'b1, 1'b0);
                    cycle("t6_acc");
                    InValid = 1'b0;
                end
                OvClear = st_seq[i][0];
                cycle("t6_ret");
                OvClear = 1'b0;
                check("t6_sticky", OvSticky, st_exp[i]);
            end
        end
`endif

        // Asynchronous reset while FULL, with non-zero flags.
        drive(16'hFFFF, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
        OutReady = 1'b1;
        cycle("t1_pre");
        OutReady = 1'b0;
        InValid = 1'b0;
        cycle("t1_pre2");
        check("t1_flags_set", Flags != 4'b0000, 1'b1);
        drive(16'h1234, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        cycle("t1_f0");
        drive(16'h5678, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
        cycle("t1_f1");
        check("t1_full", InReady, 1'b0);
        #2 Reset = 1'b0;
        #1;
        m_q.delete(); m_flags = 4'b0000; m_sticky = 1'b0;
        check("t1_ovalid", OutValid, 1'b0);
        check("t1_flags", Flags, 4'b0000);
        check("t1_odata", OutData, 16'h0000);
        check("t1_orw", OutRegWrite, 1'b0);
        InValid = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("t1_iready", InReady, 1'b1);
        check_outputs("t1_post");

        // Randomized traffic; upstream holds an unaccepted beat stable.
        last_acc = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(InValid && !last_acc)) begin
                InValid   = ($urandom_range(0, 3) != 0);
                Result    = 16'($urandom);
                Zero      = 1'($urandom);
                Overflow  = 1'($urandom);
                CarryOut  = 1'($urandom);
                DestReg   = 3'($urandom);
                RegWrite  = 1'($urandom);
                FlagWrite = 1'($urandom);
            end
            OutReady = ($urandom_range(0, 2) != 0);
`ifdef STICKY_OVF_EN
            OvClear = ($urandom_range(0, 7) == 0);
`endif
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream neighbour of the 16-bit ALU; sits between EX and writeback.
- Captures ALU Result plus its Zero/Overflow/CarryOut flags and the writeback destination through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Delivers entries to the register-file write port in order.
- Commits the architectural flag register (N, Z, V, C) when an entry leaves the stage, so flags always match the last retired result.

Parameters:
- DATA_W, 16, width of Result / OutData
- DEST_W, 3, width of the destination register index (8 registers)

Ports:
- Clock  input  1  single system clock; all state updates on its rising edge
- Reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, deassertion takes effect at the next Clock edge
- InValid  input  1  upstream holds a valid ALU result
- InReady  output  1  stage can accept; registered, equals NOT(count==2)
- Result  input  DATA_W  ALU result
- Zero  input  1  ALU Zero flag
- Overflow  input  1  ALU Overflow flag
- CarryOut  input  1  ALU CarryOut
- DestReg  input  DEST_W  writeback register index
- RegWrite  input  1  entry writes the register file
- FlagWrite  input  1  entry updates the flag register
- OutValid  output  1  head entry valid
- OutReady  input  1  downstream accepts head entry
- OutData  output  DATA_W  head entry result
- OutDest  output  DEST_W  head entry destination
- OutRegWrite  output  1  head entry RegWrite, gated by OutValid
- Flags  output  4  architectural flags {N,Z,V,C}

Behaviour:
- Storage: two entries, head (H) and skid (S), each {Result, Zero, Overflow, CarryOut, DestReg, RegWrite, FlagWrite}. Count is 0, 1 or 2; states EMPTY, ONE, FULL.
- Accept = InValid & InReady. Retire = OutValid & OutReady.
- EMPTY: Accept loads H and moves to ONE.
- ONE, Accept only: load S, move to FULL.
- ONE, Retire only: move to EMPTY.
- ONE, Accept and Retire together: H gets the new input; stay in ONE.
- FULL: InReady=0, so Accept is impossible. Retire moves S to H and goes to ONE. No Retire: hold.
- OutValid = (count != 0). OutData, OutDest and OutRegWrite come from H. OutRegWrite = H.RegWrite & OutValid.
- Latency: an input accepted into an EMPTY stage appears on OutValid/OutData at the next edge (1 cycle).
- Throughput: 1 entry per cycle while OutReady=1.
- InReady is registered. Deassertion lags FULL by 0 cycles because it is computed from the next count. No combinational path from OutReady to InReady.
- Flags update only on Retire with H.FlagWrite=1: N <= H.Result[DATA_W-1], Z <= H.Zero, V <= H.Overflow, C <= H.CarryOut. Otherwise Flags hold.
- Ordering: strict FIFO. An entry never overtakes another.
- Handshake rules:
  - Upstream must hold InValid and its data stable until accepted.
  - The stage holds OutValid and the H contents stable until Retire.
- Reset (Reset=0, asynchronous, including mid-transfer): count=0, InReady=1 (after the reset value settles), OutValid=0, OutData=0, OutDest=0, OutRegWrite=0, Flags=4'b0000. In-flight entries are discarded.
- Stored fields are not cleared on Retire. Only valid state gates the outputs.

Optional Feature:
- Macro: STICKY_OVF_EN.
- Defined:
  - Adds output OvSticky (1 bit) and input OvClear (1 bit).
  - OvSticky sets on any Retire whose entry has Overflow=1, independent of FlagWrite.
  - OvSticky clears when OvClear=1.
  - If set and clear happen in the same cycle, set wins.
  - Reset value of OvSticky is 0.
- Not defined: neither port exists, and there is no sticky state.

Test Plan:
1. Reset with Reset=0 mid-FULL -> immediately OutValid=0, Flags=0000, OutData=0; after release, InReady=1.
2. Single entry Result=16'h8000, Overflow=1, CarryOut=1, FlagWrite=1, DestReg=3, OutReady=1 -> OutValid next cycle with OutData=16'h8000, OutDest=3; the cycle after retire, Flags=1011.
3. OutReady=0, push three back-to-back entries 16'h0001, 16'h0002, 16'h0003 -> first two accepted, InReady=0 on the third. Raise OutReady -> retires 0001, 0002, 0003 in order, no loss or duplication.
4. Streaming 10 entries with OutReady=1, InValid=1 -> one retire per cycle, count stays ONE, InReady stays 1.
5. Entry with Result=0, Zero=1, FlagWrite=0 retired after an entry that set Flags=1011 -> Flags stay 1011. RegWrite=0 entry -> OutRegWrite=0 while OutValid=1.
6. With STICKY_OVF_EN: retire an Overflow=1 entry -> OvSticky=1. Retire Overflow=0 -> stays 1. OvClear=1 in the same cycle as an Overflow=1 retire -> remains 1. OvClear alone -> 0.
